adc_driver: RTL and testbench

Capture front end for the dual high-speed ADC; the receive-side counterpart of the DAC output path. It drives the ADC clock and output-enable pins, registers the 14-bit offset-binary sample bus and out-of-range flag, and discards the converter's settling samples. It can start capture either immediately or on the DAC-side sync strobe, then emits a qualified sample stream with per-period sample index, period-start marker and capture-done flag for the DSP chain.

---
 rtl/adc_pkg.sv | 24 ++
 rtl/adc_sample_counter.sv | 38 +++
 rtl/adc_driver.sv | 143 ++++++++++++++
 tb/tb_adc_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state type, widths and code conversion for the ADC capture path
package adc_pkg;

    localparam int ADC_W        = 14;
    localparam int ADC_MIDSCALE = 8192;
    localparam int CNT_W        = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        SETTLE,
        RUN,
        DONE
    } adc_state_t;

    // With mid = 2^(ADC_W-1) this reduces to inverting the MSB.
    function automatic logic [ADC_W-1:0] ob_to_twos(
        input logic [ADC_W-1:0] code,
        input logic [ADC_W-1:0] mid
    );
        return code - mid;
    endfunction

endpackage

// File: rtl/adc_sample_counter.sv
// rtl/adc_sample_counter.sv - per-period sample index and period counter with terminal count
module adc_sample_counter
    import adc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] ptos,
    input  logic [CNT_W-1:0] n_periods,
    output logic [CNT_W-1:0] idx,
    output logic             terminal
);

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] p_eff;
    logic             wrap;

    // A zero period length behaves as one sample per period.
    assign p_eff    = (ptos == '0) ? CNT_W'(1) : ptos;
    assign wrap     = (idx == p_eff - CNT_W'(1));
    assign terminal = wrap && (n_periods != '0) && (period == n_periods - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx    <= '0;
            period <= '0;
        end else if (advance) begin
            if (wrap) begin
                idx    <= '0;
                period <= period + CNT_W'(1);
            end else begin
                idx <= idx + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_driver.sv
// rtl/adc_driver.sv - ADC capture front end: pin control, input pipe, capture FSM, qualified stream
module adc_driver
    import adc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int MIDSCALE      = ADC_MIDSCALE,
    parameter int SIGNED_OUT    = 1
) (
    input  logic             CLK_65,
    input  logic             reset,
    input  logic             enable,
    input  logic             seleccion_sync,
    input  logic             sync_in,
    input  logic [CNT_W-1:0] ptos_x_ciclo,
    input  logic [CNT_W-1:0] n_ciclos,
    input  logic [ADC_W-1:0] ADC_DA,
    input  logic             ADC_OTR_A,
    output logic             ADC_CLK_A,
    output logic             ADC_OEB_A,
    output logic [ADC_W-1:0] data_out,
    output logic             data_valid,
    output logic [CNT_W-1:0] sample_idx,
    output logic             cycle_start,
    output logic             overrange,
    output logic             done
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ADC_W-1:0] MID         = ADC_W'(MIDSCALE);
    localparam adc_state_t       START_STATE = (SETTLE_CYCLES == 0) ? RUN : SETTLE;

    adc_state_t       state;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] p_lat;
    logic [CNT_W-1:0] n_lat;
    logic [ADC_W-1:0] s1_data;
    logic             s1_otr;
    logic             run_d1;
    logic             done_d1;
    logic [CNT_W-1:0] idx_d1;
    logic [CNT_W-1:0] cnt_idx;
    logic             cnt_terminal;

    assign ADC_CLK_A = CLK_65;

    adc_sample_counter u_counter (
        .clk       (CLK_65),
        .reset     (reset),
        .clear     (state == IDLE),
        .advance   (state == RUN),
        .ptos      (p_lat),
        .n_periods (n_lat),
        .idx       (cnt_idx),
        .terminal  (cnt_terminal)
    );

    always_ff @(posedge CLK_65) begin
        if (reset) begin
            state      <= IDLE;
            ADC_OEB_A  <= 1'b1;
            settle_cnt <= '0;
            p_lat      <= '0;
            n_lat      <= '0;
        end else if (!enable) begin
            state     <= IDLE;
            ADC_OEB_A <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    p_lat      <= ptos_x_ciclo;
                    n_lat      <= n_ciclos;
                    settle_cnt <= '0;
                    ADC_OEB_A  <= 1'b0;
                    state      <= seleccion_sync ? WAIT_SYNC : START_STATE;
                end
                WAIT_SYNC: begin
                    if (sync_in) begin
                        state <= START_STATE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (cnt_terminal) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_65) begin
        if (reset) begin
            s1_data  <= '0;
            s1_otr   <= 1'b0;
            data_out <= '0;
        end else begin
            s1_data  <= ADC_DA;
            s1_otr   <= ADC_OTR_A;
            data_out <= (SIGNED_OUT != 0) ? ob_to_twos(s1_data, MID) : s1_data;
        end
    end

    // Qualifiers trail the state by two clocks to line up with the data pipe;
    // dropping enable kills whatever is still in flight.
    always_ff @(posedge CLK_65) begin
        if (reset) begin
            run_d1      <= 1'b0;
            done_d1     <= 1'b0;
            idx_d1      <= '0;
            data_valid  <= 1'b0;
            sample_idx  <= '0;
            cycle_start <= 1'b0;
            done        <= 1'b0;
            overrange   <= 1'b0;
        end else begin
            run_d1      <= enable && (state == RUN);
            done_d1     <= enable && (state == DONE);
            idx_d1      <= cnt_idx;
            data_valid  <= enable && run_d1;
            sample_idx  <= (enable && run_d1) ? idx_d1 : '0;
            cycle_start <= enable && run_d1 && (idx_d1 == '0);
            done        <= enable && done_d1;
            if ((state == IDLE) && enable) begin
                overrange <= 1'b0;
            end else if (enable && run_d1 && s1_otr) begin
                overrange <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_driver.sv
// tb/tb_adc_driver.sv - directed self-checking bench for adc_driver
module tb_adc_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        seleccion_sync;
    logic        sync_in;
    logic [15:0] ptos;
    logic [15:0] ncic;
    logic [13:0] adc_da;
    logic        adc_otr;
    logic        adc_clk;
    logic        adc_oeb;
    logic [13:0] data_out;
    logic        data_valid;
    logic [15:0] sample_idx;
    logic        cycle_start;
    logic        overrange;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_driver dut (
        .CLK_65         (clk),
        .reset          (reset),
        .enable         (enable),
        .seleccion_sync (seleccion_sync),
        .sync_in        (sync_in),
        .ptos_x_ciclo   (ptos),
        .n_ciclos       (ncic),
        .ADC_DA         (adc_da),
        .ADC_OTR_A      (adc_otr),
        .ADC_CLK_A      (adc_clk),
        .ADC_OEB_A      (adc_oeb),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .sample_idx     (sample_idx),
        .cycle_start    (cycle_start),
        .overrange      (overrange),
        .done           (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; seleccion_sync = 1'b0; sync_in = 1'b0;
        ptos = 16'd4; ncic = 16'd0; adc_da = 14'd0; adc_otr = 1'b0;
        step();
        step();
        checks++; if (data_out !== 14'd0) begin failures++; $display("FAIL reset_data_out got=%0h exp=0", data_out); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", data_valid); end
        checks++; if (sample_idx !== 16'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", sample_idx); end
        checks++; if (cycle_start !== 1'b0) begin failures++; $display("FAIL reset_cs got=%0b exp=0", cycle_start); end
        checks++; if (overrange !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%0b exp=0", overrange); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (adc_oeb !== 1'b1) begin failures++; $display("FAIL reset_oeb got=%0b exp=1", adc_oeb); end
        checks++; if (adc_clk !== 1'b1) begin failures++; $display("FAIL adc_clk_high got=%0b exp=1", adc_clk); end
        @(negedge clk); #1;
        checks++; if (adc_clk !== 1'b0) begin failures++; $display("FAIL adc_clk_low got=%0b exp=0", adc_clk); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_free_run();
        seleccion_sync = 1'b0; ptos = 16'd4; ncic = 16'd0; enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++; if (data_valid !== (i >= 6)) begin failures++; $display("FAIL free_valid i=%0d got=%0b exp=%0b", i, data_valid, (i >= 6)); end
            if (i == 0) begin
                checks++; if (adc_oeb !== 1'b0) begin failures++; $display("FAIL free_oeb got=%0b exp=0", adc_oeb); end
            end
            if (i >= 6) begin
                checks++; if (data_out !== 14'(i - 6)) begin failures++; $display("FAIL free_data i=%0d got=%0h exp=%0h", i, data_out, 14'(i - 6)); end
                checks++; if (sample_idx !== 16'((i - 6) % 4)) begin failures++; $display("FAIL free_idx i=%0d got=%0d exp=%0d", i, sample_idx, (i - 6) % 4); end
                checks++; if (cycle_start !== ((i - 6) % 4 == 0)) begin failures++; $display("FAIL free_cs i=%0d got=%0b", i, cycle_start); end
            end
            adc_da = 14'(8188 + i);
        end
    endtask

    task automatic test_sync();
        enable = 1'b0;
        step();
        checks++; if (adc_oeb !== 1'b1) begin failures++; $display("FAIL sync_idle_oeb got=%0b exp=1", adc_oeb); end
        seleccion_sync = 1'b1; enable = 1'b1; sync_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++; if (data_valid !== (i >= 26)) begin failures++; $display("FAIL sync_valid i=%0d got=%0b exp=%0b", i, data_valid, (i >= 26)); end
            if (i == 26) begin
                checks++; if (sample_idx !== 16'd0) begin failures++; $display("FAIL sync_idx got=%0d exp=0", sample_idx); end
                checks++; if (cycle_start !== 1'b1) begin failures++; $display("FAIL sync_cs got=%0b exp=1", cycle_start); end
                checks++; if (data_out !== 14'h2048) begin failures++; $display("FAIL sync_data got=%0h exp=2048", data_out); end
            end
            adc_da  = 14'(i * 3);
            sync_in = (i == 19);
        end
        sync_in = 1'b0;
    endtask

    task automatic test_p3n2();
        int nvalid;
        nvalid = 0;
        enable = 1'b0;
        step();
        seleccion_sync = 1'b0; ptos = 16'd3; ncic = 16'd2; enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++; if (data_valid !== (i >= 6 && i <= 11)) begin failures++; $display("FAIL p3n2_valid i=%0d got=%0b", i, data_valid); end
            if (i >= 6 && i <= 11) begin
                checks++; if (sample_idx !== 16'((i - 6) % 3)) begin failures++; $display("FAIL p3n2_idx i=%0d got=%0d exp=%0d", i, sample_idx, (i - 6) % 3); end
            end
            checks++; if (done !== (i >= 12)) begin failures++; $display("FAIL p3n2_done i=%0d got=%0b exp=%0b", i, done, (i >= 12)); end
            if (data_valid === 1'b1) nvalid++;
            if (i == 7) ptos = 16'd5;
        end
        checks++; if (nvalid != 6) begin failures++; $display("FAIL p3n2_count got=%0d exp=6", nvalid); end
        checks++; if (adc_oeb !== 1'b0) begin failures++; $display("FAIL p3n2_done_oeb got=%0b exp=0", adc_oeb); end
        enable = 1'b0;
        step();
        checks++; if (adc_oeb !== 1'b1) begin failures++; $display("FAIL p3n2_idle_oeb got=%0b exp=1", adc_oeb); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL p3n2_idle_done got=%0b exp=0", done); end
    endtask

    task automatic test_overrange();
        ptos = 16'd4; ncic = 16'd0; seleccion_sync = 1'b0; adc_otr = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            checks++; if (overrange !== (i >= 10)) begin failures++; $display("FAIL ovr i=%0d got=%0b exp=%0b", i, overrange, (i >= 10)); end
            adc_otr = (i == 2 || i == 8);
        end
        adc_otr = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (data_valid === 1'b1 && sample_idx === 16'd1) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL drop_find got=0 exp=1"); end
        checks++; if (overrange !== 1'b1) begin failures++; $display("FAIL drop_ovr_before got=%0b exp=1", overrange); end
        enable = 1'b0;
        step();
        step();
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL drop_valid got=%0b exp=0", data_valid); end
        checks++; if (adc_oeb !== 1'b1) begin failures++; $display("FAIL drop_oeb got=%0b exp=1", adc_oeb); end
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                checks++; if (overrange !== 1'b0) begin failures++; $display("FAIL rearm_ovr got=%0b exp=0", overrange); end
            end
            if (i == 6) begin
                checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL rearm_valid got=%0b exp=1", data_valid); end
                checks++; if (sample_idx !== 16'd0) begin failures++; $display("FAIL rearm_idx got=%0d exp=0", sample_idx); end
                checks++; if (cycle_start !== 1'b1) begin failures++; $display("FAIL rearm_cs got=%0b exp=1", cycle_start); end
            end
        end
    endtask

    task automatic test_reset_p0();
        enable = 1'b0;
        step();
        ptos = 16'd0; ncic = 16'd0; adc_da = 14'h1555; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            adc_otr = (i >= 4 && i < 7);
        end
        adc_otr = 1'b0;
        checks++; if (overrange !== 1'b1) begin failures++; $display("FAIL p0_ovr got=%0b exp=1", overrange); end
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL p0_valid got=%0b exp=1", data_valid); end
        checks++; if (data_out !== 14'h3555) begin failures++; $display("FAIL p0_data got=%0h exp=3555", data_out); end
        reset = 1'b1;
        step();
        checks++; if (data_out !== 14'd0) begin failures++; $display("FAIL rst_run_data got=%0h exp=0", data_out); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_run_valid got=%0b exp=0", data_valid); end
        checks++; if (sample_idx !== 16'd0) begin failures++; $display("FAIL rst_run_idx got=%0d exp=0", sample_idx); end
        checks++; if (cycle_start !== 1'b0) begin failures++; $display("FAIL rst_run_cs got=%0b exp=0", cycle_start); end
        checks++; if (overrange !== 1'b0) begin failures++; $display("FAIL rst_run_ovr got=%0b exp=0", overrange); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_run_done got=%0b exp=0", done); end
        checks++; if (adc_oeb !== 1'b1) begin failures++; $display("FAIL rst_run_oeb got=%0b exp=1", adc_oeb); end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++; if (data_valid !== (i >= 6)) begin failures++; $display("FAIL p0_restart_valid i=%0d got=%0b exp=%0b", i, data_valid, (i >= 6)); end
            if (i >= 6) begin
                checks++; if (sample_idx !== 16'd0) begin failures++; $display("FAIL p0_idx i=%0d got=%0d exp=0", i, sample_idx); end
                checks++; if (cycle_start !== 1'b1) begin failures++; $display("FAIL p0_cs i=%0d got=%0b exp=1", i, cycle_start); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_sync();
        test_p3n2();
        test_overrange();
        test_enable_drop();
        test_reset_p0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
